// File: rtl/trigger_dbg_pkg.sv
// Shared types and helpers for the trigger debug blocks: capture FSM states,
// default sizing and the small arithmetic helpers used by the stall detector.
package trigger_dbg_pkg;

    typedef enum logic {
        ARMED    = 1'b0,
        CAPTURED = 1'b1
    } cap_state_t;

    localparam int          DEF_N_CH      = 8;
    localparam int          DEF_CNT_W     = 16;
    localparam logic [31:0] DEF_PROD_MASK = 32'h0000_00F0;

    // Increment that sticks at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/trigger_stall_counter.sv
// One monitored AXIS channel: decodes a stall from the VALID/READY tap, counts
// the consecutive stall run and flags the channel once the run reaches thresh.
module trigger_stall_counter
    import trigger_dbg_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter bit PROD  = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] thresh,
    input  logic             tvalid,
    input  logic             tready,
    output logic             block_d,
    output logic             block_q,
    output logic [CNT_W-1:0] cnt_q
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             stall;
    logic [CNT_W-1:0] inc;
    logic [CNT_W-1:0] thr_eff;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // Producers stall on unaccepted data, consumers on data that never arrives.
        stall   = PROD ? (tvalid & ~tready) : (tready & ~tvalid);
        inc     = CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));
        thr_eff = (thresh == '0) ? CNT_W'(1) : thresh;
        cnt_d   = '0;
        block_d = 1'b0;
        if (en && stall) begin
            cnt_d   = inc;
            block_d = (inc >= thr_eff);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            block_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            block_q <= block_d;
        end
    end

endmodule

// File: rtl/trigger_axis_stall_detector.sv
// Per-channel AXIS stall detection feeding the deadlock monitor, plus a sticky
// capture of the first channel to block and its stall length.
module trigger_axis_stall_detector
    import trigger_dbg_pkg::*;
#(
    parameter int              N_CH      = DEF_N_CH,
    parameter int              CNT_W     = DEF_CNT_W,
    parameter logic [N_CH-1:0] PROD_MASK = N_CH'(DEF_PROD_MASK),
    parameter int              IDX_W     = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] thresh,
    input  logic             clear,
    input  logic [N_CH-1:0]  tvalid,
    input  logic [N_CH-1:0]  tready,
    output logic [N_CH-1:0]  axis_block_sigs,
    output logic             any_block,
    output logic             cap_valid,
    output logic [IDX_W-1:0] cap_idx,
    output logic [CNT_W-1:0] cap_len
);

    logic [N_CH-1:0]  block_d;
    logic [N_CH-1:0]  block_q;
    logic [CNT_W-1:0] cnt_q [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            trigger_stall_counter #(
                .CNT_W (CNT_W),
                .PROD  (PROD_MASK[gi])
            ) u_cnt (
                .clock   (clock),
                .reset   (reset),
                .en      (en),
                .thresh  (thresh),
                .tvalid  (tvalid[gi]),
                .tready  (tready[gi]),
                .block_d (block_d[gi]),
                .block_q (block_q[gi]),
                .cnt_q   (cnt_q[gi])
            );
        end
    endgenerate

    cap_state_t       state_q, state_d;
    logic             any_block_q;
    logic             cap_valid_q, cap_valid_d;
    logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
    logic [CNT_W-1:0] cap_len_q, cap_len_d;
    logic [IDX_W-1:0] first_idx;

    always_comb begin
        first_idx   = IDX_W'(lowest_set(32'(block_q)));
        state_d     = state_q;
        cap_valid_d = cap_valid_q;
        cap_idx_d   = cap_idx_q;
        cap_len_d   = cap_len_q;
        // A clear re-arms even when a block is present; a still-present block
        // is then captured one cycle later.
        if (clear) begin
            state_d     = ARMED;
            cap_valid_d = 1'b0;
            cap_idx_d   = '0;
            cap_len_d   = '0;
        end else if (state_q == ARMED && any_block_q) begin
            state_d     = CAPTURED;
            cap_valid_d = 1'b1;
            cap_idx_d   = first_idx;
            cap_len_d   = cnt_q[first_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ARMED;
            any_block_q <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
            cap_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            any_block_q <= |block_d;
            cap_valid_q <= cap_valid_d;
            cap_idx_q   <= cap_idx_d;
            cap_len_q   <= cap_len_d;
        end
    end

    assign axis_block_sigs = block_q;
    assign any_block       = any_block_q;
    assign cap_valid       = cap_valid_q;
    assign cap_idx         = cap_idx_q;
    assign cap_len         = cap_len_q;

endmodule

// File: tb/tb_trigger_axis_stall_detector.sv
// Bench for the AXIS stall detector: a default instance and a 4-bit-counter
// instance share stimulus and are checked against a run-length model.
module tb_trigger_axis_stall_detector;

    localparam logic [7:0] PMASK = 8'hF0;

    logic        clock = 1'b0;
    logic        reset, en, clear;
    logic [15:0] thresh;
    logic [3:0]  thresh_s;
    logic [7:0]  tvalid, tready;

    logic [7:0]  blk0, blk1;
    logic        any0, any1, cv0, cv1;
    logic [2:0]  ci0, ci1;
    logic [15:0] cl0;
    logic [3:0]  cl1;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    assign thresh_s = thresh[3:0];

    always #5 clock = ~clock;

    trigger_axis_stall_detector dut (
        .clock (clock), .reset (reset), .en (en), .thresh (thresh), .clear (clear),
        .tvalid (tvalid), .tready (tready), .axis_block_sigs (blk0), .any_block (any0),
        .cap_valid (cv0), .cap_idx (ci0), .cap_len (cl0)
    );

    trigger_axis_stall_detector #(
        .N_CH (8), .CNT_W (4), .PROD_MASK (8'hF0), .IDX_W (3)
    ) dut_s (
        .clock (clock), .reset (reset), .en (en), .thresh (thresh_s), .clear (clear),
        .tvalid (tvalid), .tready (tready), .axis_block_sigs (blk1), .any_block (any1),
        .cap_valid (cv1), .cap_idx (ci1), .cap_len (cl1)
    );

    // Model: per-channel length of the current unbroken stall run.
    int         m_run [2][8];
    logic [7:0] m_blk [2];
    logic       m_any [2];
    logic       m_cv  [2];
    int         m_ci  [2];
    int         m_cl  [2];

    always @(posedge clock) begin : model
        int         thr, mx, nrun, fi;
        logic       st;
        logic [7:0] nblk;
        for (int k = 0; k < 2; k++) begin
            mx  = (k == 0) ? 65535 : 15;
            thr = (k == 0) ? int'(thresh) : int'(thresh[3:0]);
            if (thr == 0) thr = 1;
            nblk = '0;
            for (int c = 0; c < 8; c++) begin
                st = PMASK[c] ? (tvalid[c] & ~tready[c]) : (tready[c] & ~tvalid[c]);
                nrun = (reset || !en || !st) ? 0 : m_run[k][c] + 1;
                nblk[c] = (nrun >= thr);
                m_run[k][c] <= nrun;
            end
            m_blk[k] <= nblk;
            m_any[k] <= |nblk;
            if (reset || clear) begin
                m_cv[k] <= 1'b0;
                m_ci[k] <= 0;
                m_cl[k] <= 0;
            end else if (m_cv[k] !== 1'b1 && m_any[k] === 1'b1) begin
                fi = 0;
                for (int c = 7; c >= 0; c--) if (m_blk[k][c]) fi = c;
                m_cv[k] <= 1'b1;
                m_ci[k] <= fi;
                m_cl[k] <= (m_run[k][fi] > mx) ? mx : m_run[k][fi];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_on) begin
            check("blk0", 32'(blk0), 32'(m_blk[0]));
            check("any0", 32'(any0), 32'(m_any[0]));
            check("cv0",  32'(cv0),  32'(m_cv[0]));
            check("ci0",  32'(ci0),  32'(m_ci[0]));
            check("cl0",  32'(cl0),  32'(m_cl[0]));
            check("blk1", 32'(blk1), 32'(m_blk[1]));
            check("any1", 32'(any1), 32'(m_any[1]));
            check("cv1",  32'(cv1),  32'(m_cv[1]));
            check("ci1",  32'(ci1),  32'(m_ci[1]));
            check("cl1",  32'(cl1),  32'(m_cl[1]));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; clear = 1'b0; thresh = 16'd4;
        tvalid = '0; tready = '0;
        tick();
        cmp_on = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_blk", 32'(blk0), 32'd0);
        check("rst_cv",  32'(cv0),  32'd0);
        check("rst_cl",  32'(cl0),  32'd0);

        // Threshold hit on producer ch5
        tvalid[5] = 1'b1;
        repeat (3) tick();
        check("t1_pre", 32'(blk0[5]), 32'd0);
        tick();
        check("t1_rise", 32'(blk0[5]), 32'd1);
        check("t1_any",  32'(any0), 32'd1);
        tick();
        check("t1_cv",   32'(cv0), 32'd1);
        check("t1_ci",   32'(ci0), 32'd5);
        check("t1_cl",   32'(cl0), 32'd4);
        check("t1_cl_s", 32'(cl1), 32'd4);
        check("t1_model_cl", 32'(m_cl[0]), 32'd4);
        repeat (5) tick();
        tready[5] = 1'b1;
        tick();
        check("t1_fall", 32'(blk0[5]), 32'd0);
        tvalid = '0; tready = '0;
        pulse_clear();
        check("t1_clr", 32'(cv0), 32'd0);

        // Two short consumer runs on ch1, split by a handshake
        tready[1] = 1'b1;
        repeat (3) begin tick(); check("t2_run1", 32'(blk0), 32'd0); end
        tvalid[1] = 1'b1;
        tick();
        tvalid[1] = 1'b0;
        repeat (3) begin tick(); check("t2_run2", 32'(blk0), 32'd0); end
        check("t2_cv", 32'(cv0), 32'd0);
        tready[1] = 1'b0;
        tick();

        // Simultaneous ch2 (consumer) and ch6 (producer)
        thresh = 16'd8;
        tready[2] = 1'b1; tvalid[6] = 1'b1;
        repeat (7) tick();
        check("t3_pre", 32'(blk0), 32'd0);
        tick();
        check("t3_both", 32'(blk0), 32'h44);
        tick();
        check("t3_ci",   32'(ci0), 32'd2);
        check("t3_cl",   32'(cl0), 32'd8);
        check("t3_ci_s", 32'(ci1), 32'd2);
        tvalid = '0; tready = '0;
        pulse_clear();

        // Clear while ch3 stays blocked
        thresh = 16'd2;
        tready[3] = 1'b1;
        repeat (6) tick();
        check("t4_cv_before", 32'(cv0), 32'd1);
        pulse_clear();
        check("t4_cv_drop", 32'(cv0), 32'd0);
        tick();
        check("t4_cv_again", 32'(cv0), 32'd1);
        check("t4_ci", 32'(ci0), 32'd3);
        check("t4_cl", 32'(cl0), 32'd7);
        tready = '0;
        pulse_clear();

        // Saturation with thresh=0 on ch0
        thresh = 16'd0;
        tready[0] = 1'b1;
        tick();
        check("t5_rise",   32'(blk0[0]), 32'd1);
        check("t5_rise_s", 32'(blk1[0]), 32'd1);
        repeat (36) tick();
        pulse_clear();
        tick();
        check("t5_cl",     32'(cl0), 32'd38);
        check("t5_cl_sat", 32'(cl1), 32'd15);
        tick();
        check("t5_hold_s", 32'(blk1[0]), 32'd1);

        // Enable drop then reset, ch4 blocked
        tready[0] = 1'b0;
        thresh = 16'd2;
        tvalid[4] = 1'b1;
        repeat (3) tick();
        check("t6_blk", 32'(blk0[4]), 32'd1);
        en = 1'b0;
        tick();
        check("t6_en_blk", 32'(blk0), 32'd0);
        check("t6_en_any", 32'(any0), 32'd0);
        check("t6_en_cv",  32'(cv0),  32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_cv", 32'(cv0), 32'd0);
        check("t6_rst_cl", 32'(cl0), 32'd0);
        check("t6_rst_s",  32'(cv1), 32'd0);
        en = 1'b1;
        tvalid = '0;

        // Randomized traffic with sticky-ish VALID/READY
        repeat (3000) begin
            for (int c = 0; c < 8; c++) begin
                if ($urandom_range(0, 7) == 0) tvalid[c] = ~tvalid[c];
                if ($urandom_range(0, 7) == 0) tready[c] = ~tready[c];
            end
            if ($urandom_range(0, 49) == 0) thresh = 16'($urandom_range(0, 12));
            en    = ($urandom_range(0, 39) != 0);
            clear = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; clear = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trigger_axis_stall_detector.md
Name: trigger_axis_stall_detector

Overview:
- Source side of the deadlock-monitor interface: watches the TVALID/TREADY pairs of the trigger core's AXI-Stream ports and produces the per-channel `axis_block_sigs` vector that the deadlock monitor ORs.
- Counts consecutive stall cycles per channel and flags a channel once its stall run reaches a runtime threshold.
- Latches a sticky diagnostic: the first channel to block and the stall length at capture, held for software readout until cleared.

Parameters:
- N_CH, 8, number of monitored AXIS channels (1..32).
- CNT_W, 16, width of the per-channel stall counters and of `thresh`.
- PROD_MASK, 8'hF0, per-channel direction. 1 = producer-side port, where stall = tvalid & ~tready. 0 = consumer-side port, where stall = tready & ~tvalid.
- IDX_W, 3, width of the channel index, equal to clog2(N_CH) with a minimum of 1.

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous, active-high.
- en  in  1  detector enable.
- thresh  in  CNT_W  consecutive stall cycles needed to flag a channel; 0 is treated as 1.
- clear  in  1  single-cycle pulse; re-arms the capture logic.
- tvalid  in  N_CH  tap of each channel's TVALID.
- tready  in  N_CH  tap of each channel's TREADY.
- axis_block_sigs  out  N_CH  registered per-channel block flags.
- any_block  out  1  registered OR of axis_block_sigs.
- cap_valid  out  1  sticky; a capture is held.
- cap_idx  out  IDX_W  first-blocked channel.
- cap_len  out  CNT_W  stall counter of cap_idx at the capture cycle.

Behaviour:
- Reset: every counter is 0, and axis_block_sigs, any_block, cap_valid, cap_idx and cap_len are all 0. The FSM is in ARMED.
- Stall per channel i:
  - Producer side (PROD_MASK[i]=1): stall[i] = tvalid[i] & ~tready[i].
  - Consumer side (PROD_MASK[i]=0): stall[i] = tready[i] & ~tvalid[i].
  - Inputs are used combinationally. There are no input registers.
- Counter per channel: cnt[i] <= stall[i] ? sat(cnt[i]+1) : 0. It saturates at 2^CNT_W-1 and never wraps.
- Block flag: axis_block_sigs[i] <= stall[i] & (sat(cnt[i]+1) >= max(thresh,1)).
  - It asserts in the cycle after the thresh-th consecutive stall cycle.
  - It deasserts in the cycle after the first non-stall cycle.
  - A completed handshake, or a cycle with valid=0 and ready=0, breaks the run.
- any_block is registered from the same next-state values, so it is coincident with axis_block_sigs.
- en=0: counters are held at 0 and axis_block_sigs and any_block are 0 one cycle later. Capture state is retained. Counting restarts from 0 when en returns to 1.
- thresh changes take effect on the next cycle's comparison. A running count is not reset by a thresh change.
- FSM:
  - ARMED to CAPTURED on the first cycle that any_block=1. In that cycle: cap_valid <= 1, cap_idx <= the lowest set index of axis_block_sigs, cap_len <= that channel's cnt. Latency from any_block rising to cap_valid rising is 1 cycle.
  - CAPTURED: cap_idx and cap_len are frozen. Later blocks are ignored.
  - CAPTURED to ARMED on clear. cap_valid <= 0 and cap_idx/cap_len are zeroed.
  - clear and any_block in the same cycle: clear wins and the FSM goes to ARMED. If any_block is still 1 in the next cycle, a new capture occurs one cycle later.
  - clear in ARMED has no effect.
- Simultaneous blocks: when several channels assert in the same cycle, the lowest index is captured.
- Reset mid-stall: all counters and flags clear. Counting resumes after reset deasserts.

Decomposition:
- Shared package trigger_dbg_pkg holds:
  - the FSM state enum (ARMED, CAPTURED),
  - the default N_CH, CNT_W and PROD_MASK constants,
  - a function for the saturating increment,
  - a lowest-set-bit priority-encode function.
- One sub-module, trigger_stall_counter, handles a single channel: stall decode, saturating counter and threshold compare. It is instantiated N_CH times. Capture and FSM logic sit in the top level.

Test Plan:
1. Threshold hit: thresh=4, ch5 (producer) with tvalid=1 and tready=0 from cycle 10. axis_block_sigs[5] rises at cycle 14, cap_valid=1 at 15, cap_idx=5, cap_len=4. With tready=1 at cycle 20, the flag falls at 21.
2. Short stall: ch1 (consumer) with tready=1 and tvalid=0 for 3 cycles, thresh=4. No flag, cap_valid stays 0. An immediate second 3-cycle run also produces no flag, confirming the counter reset between runs.
3. Simultaneous: ch2 and ch6 stall from the same cycle, thresh=8. Both flags rise together and cap_idx=2.
4. Clear collision: hold ch3 blocked and pulse clear. cap_valid=0 for one cycle, then 1 again with cap_idx=3 and cap_len equal to the current count.
5. Saturation: CNT_W=4, thresh=0, ch0 stalled for 40 cycles. The flag rises after the first stall cycle, the counter holds at 15, and the flag stays 1 with no wrap.
6. Enable/reset: with ch4 blocked, drop en. The flags are 0 the next cycle while cap_valid holds. A reset pulse then clears all outputs to 0.
